// File: rtl/divu_gen_if.sv
// Internal-bus (IBUS) connection for the divider register window.
// The CPU side is the master; the divider is the slave.
interface divu_gen_if;
    logic [31:0] IBUS_A;
    logic [31:0] IBUS_DI;
    logic [31:0] IBUS_DO;
    logic        IBUS_WE;
    logic        IBUS_REQ;
    logic        IBUS_BUSY;
    logic        IBUS_ACT;

    modport master (
        output IBUS_A, IBUS_DI, IBUS_WE, IBUS_REQ,
        input  IBUS_DO, IBUS_BUSY, IBUS_ACT
    );

    modport slave (
        input  IBUS_A, IBUS_DI, IBUS_WE, IBUS_REQ,
        output IBUS_DO, IBUS_BUSY, IBUS_ACT
    );
endinterface

// File: rtl/divu_gen.sv
// Memory-mapped W/W and 2W/W integer divider (signed or unsigned).
// Uses restoring division, resolving BPS quotient bits per clock-enabled cycle.
module divu_gen #(
    parameter int          W         = 32,
    parameter int          BPS       = 1,
    parameter logic [31:0] BASE_ADDR = 32'hFFFFFF00
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CE,
    divu_gen_if.slave  ibus,
    output logic       IRQ,
    output logic [7:0] VEC
);
    localparam int NSTEP = W / BPS;
    localparam int CW    = $clog2(NSTEP + 1);
    localparam logic [W-1:0] MIN_MAG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] MAX_POS = ~MIN_MAG;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_FIX, S_WB} state_t;

    state_t          state_reg;
    logic [W-1:0]    dvsr_reg, dvdnth_reg, dvdntl_reg;
    logic [31:0]     vcrdiv_reg, do_reg;
    logic            ovf_reg, ovfie_reg, uns_reg, sat_reg;
    logic [W-1:0]    rem_reg, quo_reg, dvs_reg;
    logic            sgn_reg, qneg_reg, rneg_reg, pend_ovf_reg;
    logic [CW-1:0]   cnt_reg;

    logic            win_sel, busy_st, conflict, stall, acc, start;
    logic [2:0]      off;
    logic [31:0]     rd_data;
    logic            unused_ok;

    function automatic logic [31:0] ext32(input logic [W-1:0] v, input logic zext);
        logic [31:0] r;
        r        = {32{~zext & v[W-1]}};
        r[W-1:0] = v;
        return r;
    endfunction

    assign win_sel   = (ibus.IBUS_A[31:5] == BASE_ADDR[31:5]);
    assign off       = ibus.IBUS_A[4:2];
    assign busy_st   = (state_reg != S_IDLE);
    assign unused_ok = ^ibus.IBUS_A[1:0];

    // Operands and result registers are locked while a division is in flight;
    // only interrupt control, vector and DVCR reads pass through.
    always_comb begin
        conflict = 1'b1;
        case (off)
            3'd2:    conflict = ibus.IBUS_WE && (ibus.IBUS_DI[3:2] != {sat_reg, uns_reg});
            3'd3:    conflict = 1'b0;
            default: conflict = 1'b1;
        endcase
    end

    assign stall          = ibus.IBUS_REQ && win_sel && busy_st && conflict && !RST;
    assign acc            = CE && ibus.IBUS_REQ && win_sel && !stall;
    assign start          = acc && ibus.IBUS_WE && ((off == 3'd1) || (off == 3'd5));
    assign ibus.IBUS_BUSY = stall;
    assign ibus.IBUS_ACT  = win_sel;
    assign ibus.IBUS_DO   = do_reg;
    assign IRQ            = ovf_reg & ovfie_reg;
    assign VEC            = vcrdiv_reg[7:0];

    always_comb begin
        rd_data = '0;
        case (off)
            3'd0:             rd_data = ext32(dvsr_reg, uns_reg);
            3'd1, 3'd5, 3'd7: rd_data = ext32(dvdntl_reg, uns_reg);
            3'd2:             rd_data = {27'd0, busy_st, sat_reg, uns_reg, ovfie_reg, ovf_reg};
            3'd3:             rd_data = vcrdiv_reg;
            3'd4, 3'd6:       rd_data = ext32(dvdnth_reg, uns_reg);
            default:          rd_data = '0;
        endcase
    end

    // LOAD: operand magnitudes and the early overflow test (quotient cannot fit W bits).
    logic              dvd_neg, dvs_neg, load_ovf;
    logic [2*W-1:0]    dvd_full, dvd_mag;
    logic [W-1:0]      dvs_mag;

    assign dvd_neg  = ~uns_reg & dvdnth_reg[W-1];
    assign dvs_neg  = ~uns_reg & dvsr_reg[W-1];
    assign dvd_full = {dvdnth_reg, dvdntl_reg};
    assign dvd_mag  = dvd_neg ? -dvd_full : dvd_full;
    assign dvs_mag  = dvs_neg ? -dvsr_reg : dvsr_reg;
    assign load_ovf = (dvsr_reg == '0) || (dvd_mag[2*W-1:W] >= dvs_mag);

    // BPS chained restoring steps; rem stays below the divisor so each trial fits W+1 bits.
    genvar gi;
    generate
        for (gi = 0; gi < BPS; gi++) begin : g_step
            logic [W-1:0] rem_in, quo_in, rem_out, quo_out;
            logic [W:0]   trial;
            logic         take;
            if (gi == 0) begin : g_first
                assign rem_in = rem_reg;
                assign quo_in = quo_reg;
            end else begin : g_next
                assign rem_in = g_step[gi-1].rem_out;
                assign quo_in = g_step[gi-1].quo_out;
            end
            assign trial   = {rem_in, quo_in[W-1]};
            assign take    = (trial >= {1'b0, dvs_reg});
            assign rem_out = take ? (trial[W-1:0] - dvs_reg) : trial[W-1:0];
            assign quo_out = {quo_in[W-2:0], take};
        end
    endgenerate

    logic [W-1:0] iter_rem, iter_quo;
    logic         fix_ovf;
    logic [W-1:0] sat_val;

    assign iter_rem = g_step[BPS-1].rem_out;
    assign iter_quo = g_step[BPS-1].quo_out;
    assign fix_ovf  = sgn_reg && (qneg_reg ? (quo_reg > MIN_MAG) : quo_reg[W-1]);
    assign sat_val  = sgn_reg ? (qneg_reg ? MIN_MAG : MAX_POS) : '1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= S_IDLE;
            dvsr_reg     <= '0;
            dvdnth_reg   <= '0;
            dvdntl_reg   <= '0;
            vcrdiv_reg   <= '0;
            do_reg       <= '0;
            ovf_reg      <= 1'b0;
            ovfie_reg    <= 1'b0;
            uns_reg      <= 1'b0;
            sat_reg      <= 1'b0;
            rem_reg      <= '0;
            quo_reg      <= '0;
            dvs_reg      <= '0;
            sgn_reg      <= 1'b0;
            qneg_reg     <= 1'b0;
            rneg_reg     <= 1'b0;
            pend_ovf_reg <= 1'b0;
            cnt_reg      <= '0;
        end else if (CE) begin
            do_reg <= (acc && !ibus.IBUS_WE) ? rd_data : 32'd0;

            if (acc && ibus.IBUS_WE) begin
                case (off)
                    3'd0: dvsr_reg <= ibus.IBUS_DI[W-1:0];
                    3'd1: begin
                        dvdntl_reg <= ibus.IBUS_DI[W-1:0];
                        dvdnth_reg <= {W{~uns_reg & ibus.IBUS_DI[W-1]}};
                    end
                    3'd2: begin
                        ovf_reg   <= ovf_reg & ibus.IBUS_DI[0];
                        ovfie_reg <= ibus.IBUS_DI[1];
                        uns_reg   <= ibus.IBUS_DI[2];
                        sat_reg   <= ibus.IBUS_DI[3];
                    end
                    3'd3:    vcrdiv_reg <= ibus.IBUS_DI;
                    3'd4:    dvdnth_reg <= ibus.IBUS_DI[W-1:0];
                    3'd5:    dvdntl_reg <= ibus.IBUS_DI[W-1:0];
                    default: ;
                endcase
            end

            case (state_reg)
                S_IDLE: if (start) state_reg <= S_LOAD;
                S_LOAD: begin
                    rem_reg      <= dvd_mag[2*W-1:W];
                    quo_reg      <= dvd_mag[W-1:0];
                    dvs_reg      <= dvs_mag;
                    sgn_reg      <= ~uns_reg;
                    qneg_reg     <= dvd_neg ^ dvs_neg;
                    rneg_reg     <= dvd_neg;
                    pend_ovf_reg <= load_ovf;
                    cnt_reg      <= '0;
                    state_reg    <= load_ovf ? S_WB : S_ITER;
                end
                S_ITER: begin
                    rem_reg <= iter_rem;
                    quo_reg <= iter_quo;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CW'(NSTEP - 1)) state_reg <= S_FIX;
                end
                S_FIX: begin
                    if (sgn_reg) begin
                        quo_reg <= qneg_reg ? -quo_reg : quo_reg;
                        rem_reg <= rneg_reg ? -rem_reg : rem_reg;
                    end
                    pend_ovf_reg <= fix_ovf;
                    state_reg    <= S_WB;
                end
                S_WB: begin
                    // Placed after the CPU write so a hardware OVF set beats a same-cycle clear.
                    if (!pend_ovf_reg) begin
                        dvdntl_reg <= quo_reg;
                        dvdnth_reg <= rem_reg;
                    end else begin
                        ovf_reg <= 1'b1;
                        if (sat_reg) dvdntl_reg <= sat_val;
                    end
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end
endmodule
